// File: rtl/trap_sequencer_if.sv
// Bundles the request inputs and entry strobes of the trap sequencer.
// The master side (control unit / bench) drives requests; the slave side is the sequencer.
interface trap_sequencer_if;
  logic [7:0] Trap_Req;
  logic [5:0] Sw_Trap_Num;
  logic [3:0] Irq_Level;
  logic [3:0] PIL;
  logic       ET;
  logic [4:0] CWP_In;
  logic [6:0] Trap_Type;
  logic       TBR_tt_Ld;
  logic       Pipe_Hold;
  logic       RF_Wr;
  logic       RF_Sel;
  logic [4:0] CWP_Out;
  logic       PSR_Trap_Ld;
  logic       PC_Trap_Sel;
  logic       Error_Mode;
  logic [2:0] fsm_state;

  // Handshake: a request is taken only while the sequencer is in IDLE, on the rising
  // edge where it is present; sources keep it asserted until the trap has been entered.
  modport master (
    output Trap_Req, Sw_Trap_Num, Irq_Level, PIL, ET, CWP_In,
    input  Trap_Type, TBR_tt_Ld, Pipe_Hold, RF_Wr, RF_Sel, CWP_Out,
    input  PSR_Trap_Ld, PC_Trap_Sel, Error_Mode, fsm_state
  );

  modport slave (
    input  Trap_Req, Sw_Trap_Num, Irq_Level, PIL, ET, CWP_In,
    output Trap_Type, TBR_tt_Ld, Pipe_Hold, RF_Wr, RF_Sel, CWP_Out,
    output PSR_Trap_Ld, PC_Trap_Sel, Error_Mode, fsm_state
  );
endinterface

// File: rtl/trap_sequencer.sv
// SPARC trap entry controller: prioritises pending traps, forms tt, and steps through
// TBR load, PC/nPC save, window decrement/PSR update and vectoring.
module trap_sequencer #(
  parameter int NWINDOWS = 8
) (
  input logic             Clock,
  input logic             Reset,
  trap_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LATCH    = 3'd1,
    SAVE_PC  = 3'd2,
    SAVE_NPC = 3'd3,
    ADJ_WIN  = 3'd4,
    VECTOR   = 3'd5,
    ERROR    = 3'd6
  } state_t;

  state_t     state;
  logic       exc_pending;
  logic       irq_valid;
  logic       accept;
  logic [6:0] tt_next;
  logic [4:0] cwp_dec;

  logic [6:0] trap_type_q;
  logic       tbr_ld_q;
  logic       rf_wr_q;
  logic       rf_sel_q;
  logic [4:0] cwp_q;
  logic       psr_ld_q;
  logic       pc_sel_q;
  logic       err_q;

  always_comb begin
    exc_pending = |bus.Trap_Req;
    irq_valid   = bus.ET && ((bus.Irq_Level == 4'd15) || (bus.Irq_Level > bus.PIL));
    accept      = exc_pending || irq_valid;
    cwp_dec     = (bus.CWP_In == 5'd0) ? 5'(NWINDOWS - 1) : bus.CWP_In - 5'd1;
    casez (bus.Trap_Req)
      8'b???????1: tt_next = 7'h01;
      8'b??????10: tt_next = 7'h02;
      8'b?????100: tt_next = 7'h03;
      8'b????1000: tt_next = 7'h04;
      8'b???10000: tt_next = 7'h05;
      8'b??100000: tt_next = 7'h06;
      8'b?1000000: tt_next = 7'h07;
      8'b10000000: tt_next = {1'b1, bus.Sw_Trap_Num};
      default:     tt_next = {3'b001, bus.Irq_Level};
    endcase
  end

  // The new CWP is captured at accept so the PSR update it causes cannot feed back
  // through CWP_In and decrement it a second time before VECTOR completes.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state       <= IDLE;
      trap_type_q <= 7'd0;
      tbr_ld_q    <= 1'b0;
      rf_wr_q     <= 1'b0;
      rf_sel_q    <= 1'b0;
      cwp_q       <= 5'd0;
      psr_ld_q    <= 1'b0;
      pc_sel_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (exc_pending && !bus.ET) begin
            state <= ERROR;
            err_q <= 1'b1;
          end else if (accept) begin
            state       <= LATCH;
            trap_type_q <= tt_next;
            tbr_ld_q    <= 1'b1;
            cwp_q       <= cwp_dec;
          end
        end
        LATCH: begin
          state    <= SAVE_PC;
          tbr_ld_q <= 1'b0;
          rf_wr_q  <= 1'b1;
          rf_sel_q <= 1'b0;
        end
        SAVE_PC: begin
          state    <= SAVE_NPC;
          rf_sel_q <= 1'b1;
        end
        SAVE_NPC: begin
          state    <= ADJ_WIN;
          rf_wr_q  <= 1'b0;
          rf_sel_q <= 1'b0;
          psr_ld_q <= 1'b1;
        end
        ADJ_WIN: begin
          state    <= VECTOR;
          psr_ld_q <= 1'b0;
          pc_sel_q <= 1'b1;
        end
        VECTOR: begin
          state    <= IDLE;
          pc_sel_q <= 1'b0;
        end
        ERROR: begin
          state <= ERROR;
          err_q <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Trap_Type   = trap_type_q;
  assign bus.TBR_tt_Ld   = tbr_ld_q;
  assign bus.RF_Wr       = rf_wr_q;
  assign bus.RF_Sel      = rf_sel_q;
  assign bus.CWP_Out     = cwp_q;
  assign bus.PSR_Trap_Ld = psr_ld_q;
  assign bus.PC_Trap_Sel = pc_sel_q;
  assign bus.Error_Mode  = err_q;
  assign bus.Pipe_Hold   = (state != IDLE) || accept;
  assign bus.fsm_state   = state;

endmodule
